spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter DATA_WIDTH, default 8, sets the bits per SPI word, MSB first.
REQ-002 Parameter SYNC_STAGES, default 2, sets the synchronizer depth on sclk, ss and mosi.
REQ-003 io_mainClk  input  1  single system clock; all flops are clocked on its rising edge.
REQ-004 io_asyncResetn  input  1  asynchronous active-low reset.
REQ-005 io_spiSlave_sclk  input  1  SPI clock from the external master (mode 0: CPOL=0, CPHA=0).
REQ-006 io_spiSlave_ss  input  1  active-low slave select.
REQ-007 io_spiSlave_mosi  input  1  master-out data.
REQ-008 io_spiSlave_miso  output  1  slave-out data.
REQ-009 io_spiSlave_misoEnable  output  1  miso drive enable, for the pad tristate.
REQ-010 io_rx_valid / io_rx_ready / io_rx_payload[DATA_WIDTH]: received-word stream, block is the source.
REQ-011 io_tx_valid / io_tx_ready / io_tx_payload[DATA_WIDTH]: transmit-word stream, block is the sink.
REQ-012 io_overrun  output  1  sticky flag: a received word was dropped.
REQ-013 io_underrun  output  1  sticky flag: a word was sent without any tx data available.
REQ-014 io_clearFlags  input  1  one-cycle pulse that clears both sticky flags.

Function
REQ-015 sclk, ss and mosi each pass through SYNC_STAGES flops; edge detection uses the last stage against one extra delayed copy.
REQ-016 Legal operation requires the sclk high time and low time to each be at least 4 io_mainClk cycles.
REQ-017 Word start (ss synced falling edge, or completion of a word while ss stays low) loads the tx shifter as follows:
- If the tx holding register is full, load it and mark the holding register empty.
- Otherwise load all-ones and set io_underrun.
REQ-018 The tx holding register is one entry; io_tx_ready = holding register empty; a word is accepted on a cycle where io_tx_valid and io_tx_ready are both high.
REQ-019 On a synced sclk rising edge with ss low, shift mosi into the rx shifter LSB and increment the bit counter.
REQ-020 On a synced sclk falling edge with ss low, shift the tx shifter left by one; io_spiSlave_miso always equals the tx shifter MSB.
REQ-021 On the DATA_WIDTH-th rising edge the word completes:
- The counter wraps to 0.
- If io_rx_valid is low, or io_rx_ready is high in that same cycle, latch io_rx_payload and set io_rx_valid.
- Otherwise drop the word, set io_overrun, and leave io_rx_payload unchanged.
- The tx reload of REQ-017 happens on the following falling edge.
REQ-022 io_rx_valid falls on the cycle after a handshake (io_rx_valid and io_rx_ready high) unless a new word completes in that same cycle, in which case it stays high with the new payload.
REQ-023 io_rx_payload is stable while io_rx_valid is high and io_rx_ready is low.
REQ-024 An ss synced rising edge mid-word aborts the word:
- Partial rx bits are discarded.
- The counter is cleared.
- The tx shifter contents are discarded; no data is pushed back to the holding register.
REQ-025 io_spiSlave_misoEnable = NOT synced ss; sclk edges while ss is high are ignored.
REQ-026 io_clearFlags clears the sticky flags; a set event in the same cycle takes priority and the flag stays set.

Reset
REQ-027 While io_asyncResetn is low, all state clears immediately:
- io_rx_valid=0, io_rx_payload=0, io_tx_ready=1 (holding register empty).
- io_spiSlave_miso=1, io_spiSlave_misoEnable=0, io_overrun=0, io_underrun=0.
- Bit counter=0; synchronizer flops reset to sclk=0, ss=1, mosi=0.
REQ-028 Release of reset mid-transfer (ss already low) does not start a word until a fresh ss falling edge is seen.

Verification
REQ-029 Preload tx 0xA5; master sends 0x3C with sclk = mainClk/8 -> miso bits 1,0,1,0,0,1,0,1; io_rx_payload=0x3C, io_rx_valid=1.
REQ-030 Two back-to-back words (0x11, 0x22) with io_rx_ready held low -> payload stays 0x11; io_overrun=1 after the second word.
REQ-031 No tx preload; master sends one word -> miso all ones; io_underrun=1; io_clearFlags pulse -> io_underrun=0.
REQ-032 ss deasserted after 5 bits, then a full word 0x81 -> only 0x81 is delivered; no overrun.
REQ-033 Word completion in the same cycle as an rx handshake -> io_rx_valid stays 1 and io_rx_payload updates to the new word.
REQ-034 io_asyncResetn asserted mid-word -> all outputs take their REQ-027 values within the same cycle, and nothing is delivered until a new ss falling edge.

Source files
------------

// File: rtl/spi_slave.sv
// SPI mode-0 slave: synchronises sclk/ss/mosi into the system clock domain, shifts words
// MSB first, and exchanges them through a ready/valid rx stream and a one-entry tx holding register.
module spi_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  io_mainClk,
  input  logic                  io_asyncResetn,
  input  logic                  io_spiSlave_sclk,
  input  logic                  io_spiSlave_ss,
  input  logic                  io_spiSlave_mosi,
  output logic                  io_spiSlave_miso,
  output logic                  io_spiSlave_misoEnable,
  output logic                  io_rx_valid,
  input  logic                  io_rx_ready,
  output logic [DATA_WIDTH-1:0] io_rx_payload,
  input  logic                  io_tx_valid,
  output logic                  io_tx_ready,
  input  logic [DATA_WIDTH-1:0] io_tx_payload,
  output logic                  io_overrun,
  output logic                  io_underrun,
  input  logic                  io_clearFlags
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {ST_ARM, ST_IDLE, ST_ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   ss_d;
  logic [SYNC_STAGES:0]   fill;

  state_t                 state;
  state_t                 state_nxt;
  logic                   word_begin;
  logic                   abort;

  logic [CNT_W-1:0]       cnt;
  logic [DATA_WIDTH-1:0]  rx_shift;
  logic [DATA_WIDTH-1:0]  tx_shift;
  logic [DATA_WIDTH-1:0]  hold;
  logic                   hold_full;
  logic                   reload_pend;

  logic sclk_s, ss_s, mosi_s, fill_done;
  logic sclk_rise, sclk_fall, ss_fall;
  logic active, sample_edge, shift_edge, last_bit, word_done;
  logic load_tx, rx_accept, rx_drop, tx_take, underrun_set;
  logic [DATA_WIDTH-1:0] rx_word;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign fill_done = fill[SYNC_STAGES];

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_fall   = ~ss_s & ss_d;

  // --- input synchronisers and edge-detect delay stage
  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
      fill      <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], io_spiSlave_sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], io_spiSlave_ss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], io_spiSlave_mosi};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
      fill      <= {fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // ST_ARM holds off until the synchroniser carries the real pin and ss is seen high,
  // so a reset released with ss already low cannot fake a falling edge.
  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) state <= ST_ARM;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    word_begin = 1'b0;
    abort      = 1'b0;
    case (state)
      ST_ARM:    if (fill_done && ss_s) state_nxt = ST_IDLE;
      ST_IDLE:   if (ss_fall) begin
                   state_nxt  = ST_ACTIVE;
                   word_begin = 1'b1;
                 end
      ST_ACTIVE: if (ss_s) begin
                   state_nxt = ST_IDLE;
                   abort     = 1'b1;
                 end
      default:   state_nxt = ST_ARM;
    endcase
  end

  assign active       = (state == ST_ACTIVE) && !ss_s;
  assign sample_edge  = active & sclk_rise;
  assign shift_edge   = active & sclk_fall;
  assign last_bit     = (cnt == CNT_W'(DATA_WIDTH - 1));
  assign word_done    = sample_edge & last_bit;
  assign rx_word      = {rx_shift[DATA_WIDTH-2:0], mosi_s};
  assign load_tx      = word_begin | (shift_edge & reload_pend);
  assign rx_accept    = word_done & (~io_rx_valid | io_rx_ready);
  assign rx_drop      = word_done & ~rx_accept;
  assign tx_take      = io_tx_valid & ~hold_full;
  assign underrun_set = load_tx & ~hold_full;

  // --- shift datapath, holding register and stream/flag state
  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      cnt           <= '0;
      rx_shift      <= '0;
      tx_shift      <= '1;
      hold          <= '0;
      hold_full     <= 1'b0;
      reload_pend   <= 1'b0;
      io_rx_valid   <= 1'b0;
      io_rx_payload <= '0;
      io_overrun    <= 1'b0;
      io_underrun   <= 1'b0;
    end else begin
      if (abort || word_begin)  cnt <= '0;
      else if (sample_edge)     cnt <= last_bit ? '0 : cnt + CNT_W'(1);

      if (sample_edge) rx_shift <= rx_word;

      if (abort)           tx_shift <= '1;
      else if (load_tx)    tx_shift <= hold_full ? hold : '1;
      else if (shift_edge) tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b1};

      if (load_tx && hold_full) hold_full <= 1'b0;
      else if (tx_take)         hold_full <= 1'b1;
      if (tx_take) hold <= io_tx_payload;

      if (abort)           reload_pend <= 1'b0;
      else if (word_done)  reload_pend <= 1'b1;
      else if (shift_edge) reload_pend <= 1'b0;

      if (rx_accept)                     io_rx_valid <= 1'b1;
      else if (io_rx_valid && io_rx_ready) io_rx_valid <= 1'b0;
      if (rx_accept) io_rx_payload <= rx_word;

      if (rx_drop)            io_overrun <= 1'b1;
      else if (io_clearFlags) io_overrun <= 1'b0;

      if (underrun_set)       io_underrun <= 1'b1;
      else if (io_clearFlags) io_underrun <= 1'b0;
    end
  end

  assign io_spiSlave_miso       = tx_shift[DATA_WIDTH-1];
  assign io_spiSlave_misoEnable = ~ss_s;
  assign io_tx_ready            = ~hold_full;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bit-banged mode-0 master drives words, a scoreboard
// queue holds expected rx words and a monitor checks each rx handshake against it.
module tb_spi_slave;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sclk, ss, mosi;
  logic          miso, miso_en;
  logic          rx_valid, rx_ready;
  logic [DW-1:0] rx_payload;
  logic          tx_valid, tx_ready;
  logic [DW-1:0] tx_payload;
  logic          overrun, underrun, clear_flags;

  int total = 0;
  int errs  = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mbits;

  always #5 clk = ~clk;

  spi_slave #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .io_mainClk(clk),
    .io_asyncResetn(rst_n),
    .io_spiSlave_sclk(sclk),
    .io_spiSlave_ss(ss),
    .io_spiSlave_mosi(mosi),
    .io_spiSlave_miso(miso),
    .io_spiSlave_misoEnable(miso_en),
    .io_rx_valid(rx_valid),
    .io_rx_ready(rx_ready),
    .io_rx_payload(rx_payload),
    .io_tx_valid(tx_valid),
    .io_tx_ready(tx_ready),
    .io_tx_payload(tx_payload),
    .io_overrun(overrun),
    .io_underrun(underrun),
    .io_clearFlags(clear_flags)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every rx handshake must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          errs++;
          $display("FAIL rx_unexpected: got %0h, expected no word", rx_payload);
        end else begin
          check("rx_word", {24'h0, rx_payload}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_valid"}, {31'h0, rx_valid}, 32'h0);
    check({tag, "_rx_payload"}, {24'h0, rx_payload}, 32'h0);
    check({tag, "_tx_ready"}, {31'h0, tx_ready}, 32'h1);
    check({tag, "_miso"}, {31'h0, miso}, 32'h1);
    check({tag, "_miso_en"}, {31'h0, miso_en}, 32'h0);
    check({tag, "_overrun"}, {31'h0, overrun}, 32'h0);
    check({tag, "_underrun"}, {31'h0, underrun}, 32'h0);
  endtask

  task automatic frame_begin();
    ss = 1'b0;
    tick(4);
  endtask

  task automatic frame_end();
    tick(4);
    ss = 1'b1;
    tick(4);
  endtask

  // Sends nbits MSB first at sclk = clk/8. If hs_last, rx_ready pulses for exactly the
  // cycle in which the last rising edge completes the word (2 sync stages + edge detect).
  task automatic send(input logic [DW-1:0] data, input int nbits, input bit hs_last,
                      output logic [DW-1:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = data[DW-1-i];
      tick(4);
      got[DW-1-i] = miso;
      sclk = 1'b1;
      if (hs_last && i == nbits - 1) begin
        tick(2);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("hs_same_cycle_valid", {31'h0, rx_valid}, 32'h1);
        check("hs_same_cycle_payload", {24'h0, rx_payload}, {24'h0, data});
        tick(1);
      end else begin
        tick(4);
      end
      sclk = 1'b0;
    end
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    tick(1);
    clear_flags = 1'b0;
    tick(1);
  endtask

  task automatic drain(input int n);
    rx_ready = 1'b1;
    tick(n);
    rx_ready = 1'b0;
    tick(1);
  endtask

  initial begin
    rst_n = 1'b0; sclk = 1'b0; ss = 1'b1; mosi = 1'b0;
    rx_ready = 1'b0; tx_valid = 1'b0; tx_payload = '0; clear_flags = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(8);

    // Preloaded tx 0xA5, master sends 0x3C.
    tx_payload = 8'hA5;
    tx_valid   = 1'b1;
    tick(1);
    tx_valid   = 1'b0;
    check("preload_tx_ready", {31'h0, tx_ready}, 32'h0);
    frame_begin();
    check("load_tx_ready", {31'h0, tx_ready}, 32'h1);
    check("miso_en_active", {31'h0, miso_en}, 32'h1);
    send(8'h3C, 8, 1'b0, mbits);
    frame_end();
    check("t1_miso_bits", {24'h0, mbits}, 32'hA5);
    check("t1_rx_valid", {31'h0, rx_valid}, 32'h1);
    check("t1_rx_payload", {24'h0, rx_payload}, 32'h3C);
    exp_q.push_back(8'h3C);
    drain(3);
    check("t1_valid_drop", {31'h0, rx_valid}, 32'h0);
    pulse_clear();

    // Back-to-back 0x11, 0x22 with rx_ready low: second word dropped.
    frame_begin();
    send(8'h11, 8, 1'b0, mbits);
    send(8'h22, 8, 1'b0, mbits);
    frame_end();
    check("t2_rx_payload", {24'h0, rx_payload}, 32'h11);
    check("t2_overrun", {31'h0, overrun}, 32'h1);
    exp_q.push_back(8'h11);
    drain(3);
    pulse_clear();
    check("t2_overrun_cleared", {31'h0, overrun}, 32'h0);

    // No tx data: miso idles high, underrun set then cleared.
    check("t3_underrun_pre", {31'h0, underrun}, 32'h0);
    exp_q.push_back(8'h5A);
    rx_ready = 1'b1;
    frame_begin();
    send(8'h5A, 8, 1'b0, mbits);
    frame_end();
    rx_ready = 1'b0;
    check("t3_miso_bits", {24'h0, mbits}, 32'hFF);
    check("t3_underrun", {31'h0, underrun}, 32'h1);
    pulse_clear();
    check("t3_underrun_cleared", {31'h0, underrun}, 32'h0);

    // Aborted 5-bit fragment, then a full 0x81.
    exp_q.push_back(8'h81);
    rx_ready = 1'b1;
    frame_begin();
    send(8'hFF, 5, 1'b0, mbits);
    frame_end();
    frame_begin();
    send(8'h81, 8, 1'b0, mbits);
    frame_end();
    rx_ready = 1'b0;
    check("t4_overrun", {31'h0, overrun}, 32'h0);
    check("t4_queue_empty", exp_q.size(), 32'h0);
    pulse_clear();

    // Word completes in the same cycle as the handshake of the previous word.
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    frame_begin();
    send(8'h33, 8, 1'b0, mbits);
    send(8'h44, 8, 1'b1, mbits);
    frame_end();
    check("t5_overrun", {31'h0, overrun}, 32'h0);
    check("t5_pending_valid", {31'h0, rx_valid}, 32'h1);
    drain(3);
    check("t5_queue_empty", exp_q.size(), 32'h0);
    pulse_clear();

    // Reset mid-word, then a word with ss still low must be ignored.
    frame_begin();
    send(8'hE7, 3, 1'b0, mbits);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    tick(2);
    rst_n = 1'b1;
    tick(8);
    send(8'hC3, 8, 1'b0, mbits);
    tick(4);
    check("t6_no_delivery", {31'h0, rx_valid}, 32'h0);
    ss = 1'b1;
    tick(6);
    frame_begin();
    send(8'h96, 8, 1'b0, mbits);
    frame_end();
    check("t6_rx_valid", {31'h0, rx_valid}, 32'h1);
    check("t6_rx_payload", {24'h0, rx_payload}, 32'h96);
    exp_q.push_back(8'h96);
    drain(3);
    check("final_queue_empty", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", total, errs);
    $finish;
  end

endmodule
